// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_slave_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    // Register index width; covers the largest supported file of 16 registers.
    localparam int unsigned IDX_W = 4;

    localparam logic [APB_DATA_W-1:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

    typedef enum logic {
        StIdle,
        StAccess
    } state_e;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: maps a byte address onto a register index.
module apb_addr_decode
    import apb_slave_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] ADDR_BASE = 32'h8000_0000,
    parameter int unsigned           NUM_REGS  = 8
) (
    input  logic [APB_ADDR_W-1:0] paddr,
    output logic                  valid,
    output logic [IDX_W-1:0]      index,
    output logic                  ro_hit
);

    // Word offset from the base; the base is word aligned, so the low two
    // address bits only matter for the alignment test.
    logic [APB_ADDR_W-3:0] offset_w;

    // Range, alignment and size checks, plus the read-only register 0 hit.
    always_comb begin
        offset_w = paddr[APB_ADDR_W-1:2] - ADDR_BASE[APB_ADDR_W-1:2];
        valid    = (paddr >= ADDR_BASE) && (paddr[1:0] == 2'b00) &&
                   ({2'b00, offset_w} < NUM_REGS);
        index    = offset_w[IDX_W-1:0];
        ro_hit   = valid && (index == '0);
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a small 32-bit register file and programmable wait states.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int unsigned           SEL_INDEX   = 0,
    parameter logic [APB_ADDR_W-1:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned           NUM_REGS    = 8,
    parameter int unsigned           WAIT_CYCLES = 1,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic [2:0]            Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [APB_ADDR_W-1:0] Paddr,
    input  logic [APB_DATA_W-1:0] Pwdata,
    output logic [APB_DATA_W-1:0] Prdata,
    output logic                  Pready,
    output logic                  Pslverr,
    output logic                  proto_err
);

    logic                  sel;
    logic                  dec_valid;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_ro_hit;
    logic [APB_DATA_W-1:0] rd_word;
    logic                  wr_en;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [APB_ADDR_W-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [APB_DATA_W-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  err_q, err_d;
    logic [APB_DATA_W-1:0] rdata_q, rdata_d;
    logic                  proto_q, proto_d;
    logic [APB_DATA_W-1:0] regs_q [1:NUM_REGS-1];

    // Mask form keeps every select bit referenced while only ours matters.
    assign sel = |(Pselx & (3'b001 << SEL_INDEX));

    apb_addr_decode #(
        .ADDR_BASE (ADDR_BASE),
        .NUM_REGS  (NUM_REGS)
    ) u_decode (
        .paddr  (Paddr),
        .valid  (dec_valid),
        .index  (dec_idx),
        .ro_hit (dec_ro_hit)
    );

    // Read mux for the setup-phase data capture; invalid addresses read as zero.
    always_comb begin
        rd_word = '0;
        if (dec_valid) begin
            if (dec_idx == '0) begin
                rd_word = ID_VALUE;
            end
            for (int i = 1; i < NUM_REGS; i++) begin
                if (dec_idx == IDX_W'(i)) begin
                    rd_word = regs_q[i];
                end
            end
        end
    end

    // FSM next state, transfer capture and protocol checking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        proto_d = proto_q;
        wr_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (sel && !Penable) begin
                    state_d = StAccess;
                    cnt_d   = 3'(WAIT_CYCLES);
                    addr_d  = Paddr;
                    write_d = Pwrite;
                    wdata_d = Pwdata;
                    idx_d   = dec_idx;
                    err_d   = !dec_valid || (Pwrite && dec_ro_hit);
                    rdata_d = Pwrite ? '0 : rd_word;
                end else if (sel && Penable) begin
                    // Access phase without a preceding setup.
                    proto_d = 1'b1;
                end
            end
            StAccess: begin
                if (!sel || !Penable || (Paddr != addr_q) || (Pwrite != write_q)) begin
                    proto_d = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = StIdle;
                    wr_en   = write_q && !err_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Transfer state registers.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            proto_q <= proto_d;
        end
    end

    // Register file; writes commit at the completion edge only.
    always_ff @(posedge Hclk) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (Hreset) begin
                regs_q[i] <= '0;
            end else if (wr_en && (idx_q == IDX_W'(i))) begin
                regs_q[i] <= wdata_q;
            end
        end
    end

    // Outputs decode from registered state only.
    always_comb begin
        Pready    = (state_q == StAccess) && (cnt_q == 3'd0);
        Pslverr   = Pready && err_q;
        Prdata    = (Pready && !write_q && !err_q) ? rdata_q : '0;
        proto_err = proto_q;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (slave) for the far end of the AHB-to-APB bridge.
- Responds to one Pselx bit, decodes Paddr into a small 32-bit register file, and inserts a programmable number of wait states via Pready.
- Flags decode errors on Pslverr and latches APB protocol violations by the bridge on a sticky status output.
- Serves as the bench responder for the bridge and as a reusable peripheral template.

Parameters:
- SEL_INDEX, 0: which Pselx bit (0..2) selects this slave.
- ADDR_BASE, 32'h8000_0000: byte address of register 0.
- NUM_REGS, 8: number of 32-bit registers, 2..16.
- WAIT_CYCLES, 1: access-phase wait states before Pready, 0..7.
- ID_VALUE, 32'hA5B0_0001: read-only contents of register 0.

Ports:
- Hclk  in  1  clock; all logic on its rising edge.
- Hreset  in  1  synchronous, active-high reset.
- Pselx  in  3  one-hot slave selects from the bridge.
- Penable  in  1  APB access phase.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address.
- Pwdata  in  32  write data.
- Prdata  out  32  read data; nonzero only in the completing cycle of a read.
- Pready  out  1  transfer completes this cycle.
- Pslverr  out  1  error response; valid only when Pready=1.
- proto_err  out  1  sticky APB protocol-violation flag; cleared only by Hreset.

Behaviour:
- Reset (Hreset=1 at an edge): all registers 1..NUM_REGS-1 and every output (Prdata, Pready, Pslverr, proto_err) go to 0; FSM goes to IDLE.
- Reset mid-transfer aborts the transfer; no write commits.
- sel = Pselx[SEL_INDEX]. Other Pselx bits are ignored.
- FSM states: IDLE, ACCESS.
- IDLE, edge with sel=1 and Penable=0 (setup):
  - capture Paddr, Pwrite, Pwdata and the decode result;
  - load wait counter with WAIT_CYCLES;
  - for reads, capture register data;
  - go to ACCESS.
- IDLE, edge with sel=1 and Penable=1: protocol error; set proto_err, stay in IDLE.
- Pready = (state==ACCESS && cnt==0), decoded from state registers only, with no combinational input path.
- ACCESS, edge with sel=1 and Penable=1:
  - cnt!=0: decrement cnt.
  - cnt==0: transfer completes at this edge. A valid write updates the target register; go to IDLE.
- ACCESS, edge with sel=0, Penable=0, or Paddr/Pwrite changed from the captured values: set proto_err, abandon the transfer with no write, go to IDLE.
- Latency: with WAIT_CYCLES=W, Pready is high in the (W+1)-th access cycle. The minimum transfer is setup + 1 access cycle.
- Back-to-back transfers re-enter through IDLE: the setup immediately after a completion cycle is accepted.
- Decode: offset = Paddr - ADDR_BASE. The address is valid iff:
  - Paddr >= ADDR_BASE, and
  - Paddr[1:0]==0, and
  - offset[31:2] < NUM_REGS.
- Register map:
  - Register 0 reads ID_VALUE. Writes to it are errors.
  - Registers 1..NUM_REGS-1 are read/write.
- Errors: an invalid address or a write to register 0 gives Pslverr=1 with Pready. There is no register change, and Prdata=0.
- Pslverr is 0 whenever Pready=0.
- Read data is sampled at the setup edge. A write to the same register that completes earlier is visible, because the write commits before the next setup.

Decomposition:
- Package apb_slave_pkg: state enum (IDLE, ACCESS), APB_ADDR_W=32, APB_DATA_W=32, default ID_VALUE constant.
- Sub-module apb_addr_decode (combinational): Paddr in; valid, index, ro_hit out.
- Parent owns the FSM, wait counter, register file and error logic.

Test Plan:
- Reset with defaults: after Hreset, Prdata=0, Pready=0, Pslverr=0, proto_err=0; reading 0x8000_0000 returns 0xA5B0_0001.
- Write 0x8000_0004 ← 0xDEAD_BEEF, then read it back with WAIT_CYCLES=1:
  - write: Pready high on the 2nd access cycle;
  - read: returns 0xDEAD_BEEF with Pslverr=0.
- Write 0x8000_0000 and read 0x8000_0020 (NUM_REGS=8): both complete with Pslverr=1; reg0 is still 0xA5B0_0001; Prdata=0.
- Misaligned access to 0x8000_0006: Pslverr=1 and no register changes.
- Penable drops mid-wait (WAIT_CYCLES=3), and separately Penable=1 with no prior setup:
  - proto_err=1 and stays 1;
  - target register unchanged.
- Back-to-back traffic with WAIT_CYCLES=0 and Pselx=3'b010, SEL_INDEX=0:
  - 4 consecutive writes to regs 1..4 each complete in 2 cycles and read back correctly;
  - the Pselx=3'b010 traffic gets no response from this instance.
